// File: rtl/vx_vpu_pkg.sv
// Shared types and sizing helpers for the VPU issue splitter.
package vx_vpu_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

  // Width needed to hold a vector length in 0..max_vl.
  function automatic int vl_bits_f(input int max_vl);
    return $clog2(max_vl + 1);
  endfunction

  // Width of the beat index; never narrower than one bit.
  function automatic int beat_bits_f(input int max_vl, input int lanes);
    int nb;
    nb = (max_vl + lanes - 1) / lanes;
    return (nb <= 2) ? 1 : $clog2(nb);
  endfunction

endpackage

// File: rtl/vx_vpu_out_buf.sv
// Small circular FIFO with registered storage; a full buffer still accepts a
// push in the same cycle its head is popped.
module vx_vpu_out_buf #(
  parameter int DATAW = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  output logic             push_ok,
  output logic             valid,
  input  logic             ready,
  output logic [DATAW-1:0] data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DATAW-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             pop;
  logic             do_push;

  assign valid   = (count != '0);
  assign pop     = valid & ready;
  assign push_ok = (count != CW'(DEPTH)) | pop;
  assign do_push = push & push_ok;
  assign data    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is never reset; occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vx_vpu_issue_splitter.sv
// Routes issued instructions to the scalar or vector path and, in split mode,
// cuts each vector instruction into lane-sized beats with masks and sop/eop.
module vx_vpu_issue_splitter
  import vx_vpu_pkg::*;
#(
  parameter int DATAW     = 64,
  parameter int LANES     = 4,
  parameter int MAX_VL    = 32,
  parameter int OUT_DEPTH = 2,
  parameter int SPLIT_EN  = 1,
  localparam int VL_BITS   = vl_bits_f(MAX_VL),
  localparam int BEAT_BITS = beat_bits_f(MAX_VL, LANES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_vec,
  input  logic [VL_BITS-1:0]   in_vl,
  input  logic [DATAW-1:0]     in_data,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic [DATAW-1:0]     vec_data,
  output logic [BEAT_BITS-1:0] vec_beat,
  output logic [LANES-1:0]     vec_mask,
  output logic                 vec_sop,
  output logic                 vec_eop,
  output logic                 sca_valid,
  input  logic                 sca_ready,
  output logic [DATAW-1:0]     sca_data,
  output logic                 busy,
  output logic                 vl_err
);

  // One extra bit so k*LANES+i cannot wrap.
  localparam int VW  = VL_BITS + 1;
  localparam int LSH = $clog2(LANES);

  typedef struct packed {
    logic [DATAW-1:0]     data;
    logic [BEAT_BITS-1:0] beat;
    logic [LANES-1:0]     mask;
    logic                 sop;
    logic                 eop;
  } beat_t;

  localparam int BW = $bits(beat_t);

  split_state_e         state;
  logic [BEAT_BITS-1:0] beat_cnt;
  logic [VL_BITS-1:0]   evl;
  logic [VW-1:0]        nbeats;
  logic [VW-1:0]        k_ext;
  logic                 last;
  logic                 over_vl;
  beat_t                beat_d;
  beat_t                vec_q;
  logic                 vec_ok;
  logic                 sca_ok;
  logic                 vec_push;
  logic                 sca_push;

  // Beat generator: clamped length, beat count and lane mask for beat_cnt.
  always_comb begin
    over_vl     = (in_vl > VL_BITS'(MAX_VL));
    evl         = over_vl ? VL_BITS'(MAX_VL) : in_vl;
    nbeats      = (VW'(evl) + VW'(LANES - 1)) >> LSH;
    if (nbeats == '0) nbeats = VW'(1);
    k_ext       = VW'(beat_cnt);
    beat_d      = '0;
    beat_d.data = in_data;
    if (SPLIT_EN != 0) begin
      last        = ((k_ext + VW'(1)) == nbeats);
      beat_d.beat = beat_cnt;
      beat_d.sop  = (beat_cnt == '0);
      beat_d.eop  = last;
      for (int i = 0; i < LANES; i++) begin
        beat_d.mask[i] = (((k_ext << LSH) + VW'(i)) < VW'(evl));
      end
    end else begin
      last        = 1'b1;
      beat_d.beat = '0;
      beat_d.sop  = 1'b1;
      beat_d.eop  = 1'b1;
      beat_d.mask = '1;
    end
  end

  // Classifier: an instruction is consumed only when its last beat goes out.
  assign vec_push = reset & in_valid & in_is_vec & vec_ok;
  assign sca_push = reset & in_valid & ~in_is_vec & sca_ok;
  assign in_ready = reset & (in_is_vec ? (vec_ok & last) : sca_ok);
  assign vl_err   = vec_push & last & over_vl;
  assign busy     = (beat_cnt != '0);

  // Split FSM: advance one beat per vector push, return to IDLE on the last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else if (vec_push) begin
      if (last) begin
        state    <= ST_IDLE;
        beat_cnt <= '0;
      end else begin
        state    <= ST_SPLIT;
        beat_cnt <= beat_cnt + BEAT_BITS'(1);
      end
    end
  end

  // Upstream must keep the instruction presented until its last beat leaves.
  a_hold_during_split: assert property (
    @(posedge clk) disable iff (!reset) (state == ST_SPLIT) |-> in_valid);

  vx_vpu_out_buf #(.DATAW(BW), .DEPTH(OUT_DEPTH)) u_vec_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (vec_push),
    .push_data (beat_d),
    .push_ok   (vec_ok),
    .valid     (vec_valid),
    .ready     (vec_ready),
    .data      (vec_q)
  );

  vx_vpu_out_buf #(.DATAW(DATAW), .DEPTH(OUT_DEPTH)) u_sca_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (sca_push),
    .push_data (in_data),
    .push_ok   (sca_ok),
    .valid     (sca_valid),
    .ready     (sca_ready),
    .data      (sca_data)
  );

  assign vec_data = vec_q.data;
  assign vec_beat = vec_q.beat;
  assign vec_mask = vec_q.mask;
  assign vec_sop  = vec_q.sop;
  assign vec_eop  = vec_q.eop;

endmodule

// File: tb/tb_vx_vpu_issue_splitter.sv
// Bench for vx_vpu_issue_splitter: a split-mode instance and a pass-through
// instance, with output streams compared against a beat-list model.
module tb_vx_vpu_issue_splitter;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  beat;
    logic [3:0]  mask;
    logic        sop;
    logic        eop;
  } vbeat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_is_vec = 1'b0;
  logic [5:0]  in_vl = '0;
  logic [63:0] in_data = '0;
  logic        vec_valid, vec_ready = 1'b0, vec_sop, vec_eop;
  logic [63:0] vec_data, sca_data;
  logic [2:0]  vec_beat;
  logic [3:0]  vec_mask;
  logic        sca_valid, sca_ready = 1'b0, busy, vl_err;

  logic        p_in_valid = 1'b0, p_in_ready, p_in_is_vec = 1'b0;
  logic [5:0]  p_in_vl = '0;
  logic [63:0] p_in_data = '0;
  logic        p_vec_valid, p_vec_ready = 1'b1, p_vec_sop, p_vec_eop;
  logic [63:0] p_vec_data, p_sca_data;
  logic [2:0]  p_vec_beat;
  logic [3:0]  p_vec_mask;
  logic        p_sca_valid, p_sca_ready = 1'b1, p_busy, p_vl_err;

  int comps = 0;
  int fails = 0;
  int cyc = 0;
  int fire_cyc = 0;
  int vlerr_cnt = 0;
  bit pbusy_seen = 1'b0;

  vbeat_t      vobs[$], exp_v[$], pobs[$], exp_p[$];
  logic [63:0] sobs[$], exp_s[$];
  int          scyc[$];

  vx_vpu_issue_splitter #(.DATAW(64), .LANES(4), .MAX_VL(32), .OUT_DEPTH(2), .SPLIT_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_vec(in_is_vec), .in_vl(in_vl), .in_data(in_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .vec_beat(vec_beat), .vec_mask(vec_mask), .vec_sop(vec_sop), .vec_eop(vec_eop),
    .sca_valid(sca_valid), .sca_ready(sca_ready), .sca_data(sca_data),
    .busy(busy), .vl_err(vl_err));

  vx_vpu_issue_splitter #(.DATAW(64), .LANES(4), .MAX_VL(32), .OUT_DEPTH(2), .SPLIT_EN(0)) dut_ps (
    .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_is_vec(p_in_is_vec), .in_vl(p_in_vl), .in_data(p_in_data),
    .vec_valid(p_vec_valid), .vec_ready(p_vec_ready), .vec_data(p_vec_data),
    .vec_beat(p_vec_beat), .vec_mask(p_vec_mask), .vec_sop(p_vec_sop), .vec_eop(p_vec_eop),
    .sca_valid(p_sca_valid), .sca_ready(p_sca_ready), .sca_data(p_sca_data),
    .busy(p_busy), .vl_err(p_vl_err));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: a transfer seen at the falling edge completes at the next rising edge.
  always @(negedge clk) begin
    if (reset && vec_valid && vec_ready)
      vobs.push_back('{vec_data, vec_beat, vec_mask, vec_sop, vec_eop});
    if (reset && sca_valid && sca_ready) begin
      sobs.push_back(sca_data);
      scyc.push_back(cyc);
    end
    if (reset && vl_err) vlerr_cnt++;
    if (reset && p_vec_valid && p_vec_ready)
      pobs.push_back('{p_vec_data, p_vec_beat, p_vec_mask, p_vec_sop, p_vec_eop});
    if (p_busy) pbusy_seen = 1'b1;
  end

  // Reference: the beat list an instruction of length vl must produce.
  function automatic void model_vec(input logic [5:0] vl, input logic [63:0] d, input bit split);
    int evl, nb;
    logic [3:0] m;
    if (!split) begin
      exp_p.push_back('{d, 3'd0, 4'hF, 1'b1, 1'b1});
      return;
    end
    evl = (int'(vl) > 32) ? 32 : int'(vl);
    nb  = (evl + 3) / 4;
    if (nb == 0) nb = 1;
    for (int k = 0; k < nb; k++) begin
      m = '0;
      for (int i = 0; i < 4; i++) if (k * 4 + i < evl) m[i] = 1'b1;
      exp_v.push_back('{d, 3'(k), m, (k == 0), (k == nb - 1)});
    end
  endfunction

  task automatic clear_all();
    vobs.delete(); exp_v.delete(); sobs.delete(); exp_s.delete();
    scyc.delete(); pobs.delete(); exp_p.delete();
    vlerr_cnt = 0;
  endtask

  // Present one instruction and hold it until accepted; returns cycles waited.
  task automatic send(input bit v, input logic [5:0] vl, input logic [63:0] d, output int waited);
    in_valid = 1'b1; in_is_vec = v; in_vl = vl; in_data = d; waited = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      waited++;
      if (in_ready) begin
        @(posedge clk); #1;
        fire_cyc = cyc;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    comps++; fails++;
    $display("FAIL send_timeout: in_ready stayed low for %0d cycles, required acceptance", waited);
    in_valid = 1'b0;
    waited = -1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_is_vec = 1'b0; sca_ready = 1'b1; vec_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    comps += 5;
    if (vec_valid !== 1'b0) begin fails++; $display("FAIL reset_vec_valid: got %b want 0", vec_valid); end
    if (sca_valid !== 1'b0) begin fails++; $display("FAIL reset_sca_valid: got %b want 0", sca_valid); end
    if (in_ready !== 1'b0)  begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (vl_err !== 1'b0)    begin fails++; $display("FAIL reset_vl_err: got %b want 0", vl_err); end
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_scalar();
    int w;
    int fc[3];
    clear_all();
    for (int j = 0; j < 3; j++) begin
      exp_s.push_back(64'hA000 + 64'(j));
      send(1'b0, 6'd0, 64'hA000 + 64'(j), w);
      fc[j] = fire_cyc;
    end
    repeat (4) @(posedge clk);
    #1;
    comps++;
    if (sobs.size() != 3) begin fails++; $display("FAIL scalar_count: got %0d want 3", sobs.size()); end
    for (int j = 0; j < 3 && j < sobs.size(); j++) begin
      comps += 2;
      if (sobs[j] !== exp_s[j]) begin fails++; $display("FAIL scalar_data%0d: got %h want %h", j, sobs[j], exp_s[j]); end
      if (scyc[j] != fc[0] + j) begin fails++; $display("FAIL scalar_cycle%0d: got %0d want %0d", j, scyc[j], fc[0] + j); end
    end
    comps++;
    if (vobs.size() != 0) begin fails++; $display("FAIL scalar_no_vec: got %0d vector beats want 0", vobs.size()); end
  endtask

  task automatic test_vl10();
    int w;
    clear_all();
    model_vec(6'd10, 64'hBEEF10, 1'b1);
    send(1'b1, 6'd10, 64'hBEEF10, w);
    comps++;
    if (w != 3) begin fails++; $display("FAIL vl10_in_ready_cycle: got %0d want 3", w); end
    repeat (4) @(posedge clk);
    #1;
    comps++;
    if (vobs.size() != exp_v.size()) begin fails++; $display("FAIL vl10_count: got %0d want %0d", vobs.size(), exp_v.size()); end
    for (int j = 0; j < exp_v.size() && j < vobs.size(); j++) begin
      comps++;
      if (vobs[j] !== exp_v[j]) begin fails++; $display("FAIL vl10_beat%0d: got %h want %h", j, vobs[j], exp_v[j]); end
    end
  endtask

  task automatic test_vl_edges();
    int w;
    clear_all();
    model_vec(6'd0, 64'h0, 1'b1);
    model_vec(6'd40, 64'h40, 1'b1);
    send(1'b1, 6'd0, 64'h0, w);
    send(1'b1, 6'd40, 64'h40, w);
    repeat (4) @(posedge clk);
    #1;
    comps += 2;
    if (vobs.size() != 9) begin fails++; $display("FAIL edges_count: got %0d want 9", vobs.size()); end
    if (vlerr_cnt != 1) begin fails++; $display("FAIL edges_vl_err_pulses: got %0d want 1", vlerr_cnt); end
    for (int j = 0; j < exp_v.size() && j < vobs.size(); j++) begin
      comps++;
      if (vobs[j] !== exp_v[j]) begin fails++; $display("FAIL edges_beat%0d: got %h want %h", j, vobs[j], exp_v[j]); end
    end
  endtask

  task automatic test_stall();
    int w;
    clear_all();
    vec_ready = 1'b0; sca_ready = 1'b1;
    model_vec(6'd16, 64'h1616, 1'b1);
    exp_s.push_back(64'h5CA1);
    fork
      begin
        send(1'b1, 6'd16, 64'h1616, w);
        send(1'b0, 6'd0, 64'h5CA1, w);
      end
      begin
        repeat (6) @(posedge clk);
        #2;
        comps += 5;
        if (busy !== 1'b1)      begin fails++; $display("FAIL stall_busy: got %b want 1", busy); end
        if (in_ready !== 1'b0)  begin fails++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        if (vec_valid !== 1'b1) begin fails++; $display("FAIL stall_vec_valid: got %b want 1", vec_valid); end
        if (sca_valid !== 1'b0) begin fails++; $display("FAIL stall_sca_valid: got %b want 0", sca_valid); end
        if (dut.beat_cnt !== 3'd2) begin fails++; $display("FAIL stall_beats_buffered: got %0d want 2", dut.beat_cnt); end
        vec_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    comps += 2;
    if (vobs.size() != 4) begin fails++; $display("FAIL stall_vec_count: got %0d want 4", vobs.size()); end
    if (sobs.size() != 1) begin fails++; $display("FAIL stall_sca_count: got %0d want 1", sobs.size()); end
    for (int j = 0; j < exp_v.size() && j < vobs.size(); j++) begin
      comps++;
      if (vobs[j] !== exp_v[j]) begin fails++; $display("FAIL stall_beat%0d: got %h want %h", j, vobs[j], exp_v[j]); end
    end
    if (sobs.size() > 0) begin
      comps++;
      if (sobs[0] !== exp_s[0]) begin fails++; $display("FAIL stall_sca_data: got %h want %h", sobs[0], exp_s[0]); end
    end
  endtask

  task automatic test_passthrough();
    logic [5:0] vls[3];
    bit acc;
    vls[0] = 6'd10; vls[1] = 6'd0; vls[2] = 6'd40;
    clear_all();
    pbusy_seen = 1'b0;
    for (int j = 0; j < 3; j++) begin
      model_vec(vls[j], 64'hF000 + 64'(j), 1'b0);
      p_in_valid = 1'b1; p_in_is_vec = 1'b1; p_in_vl = vls[j]; p_in_data = 64'hF000 + 64'(j);
      @(negedge clk);
      acc = p_in_ready;
      comps++;
      if (acc !== 1'b1) begin fails++; $display("FAIL pass_in_ready%0d: got %b want 1", j, acc); end
      @(posedge clk); #1;
      p_in_valid = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    comps += 2;
    if (pobs.size() != 3) begin fails++; $display("FAIL pass_count: got %0d want 3", pobs.size()); end
    if (pbusy_seen) begin fails++; $display("FAIL pass_busy: got 1 want 0"); end
    for (int j = 0; j < exp_p.size() && j < pobs.size(); j++) begin
      comps++;
      if (pobs[j] !== exp_p[j]) begin fails++; $display("FAIL pass_beat%0d: got %h want %h", j, pobs[j], exp_p[j]); end
    end
  endtask

  task automatic test_reset_mid_split();
    int w;
    clear_all();
    vec_ready = 1'b1;
    in_valid = 1'b1; in_is_vec = 1'b1; in_vl = 6'd12; in_data = 64'hC12;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    comps += 4;
    if (vec_valid !== 1'b0) begin fails++; $display("FAIL midrst_vec_valid: got %b want 0", vec_valid); end
    if (sca_valid !== 1'b0) begin fails++; $display("FAIL midrst_sca_valid: got %b want 0", sca_valid); end
    if (busy !== 1'b0)      begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (in_ready !== 1'b0)  begin fails++; $display("FAIL midrst_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    clear_all();
    model_vec(6'd12, 64'hC12, 1'b1);
    send(1'b1, 6'd12, 64'hC12, w);
    repeat (4) @(posedge clk);
    #1;
    comps++;
    if (vobs.size() != 3) begin fails++; $display("FAIL midrst_count: got %0d want 3", vobs.size()); end
    for (int j = 0; j < exp_v.size() && j < vobs.size(); j++) begin
      comps++;
      if (vobs[j] !== exp_v[j]) begin fails++; $display("FAIL midrst_beat%0d: got %h want %h", j, vobs[j], exp_v[j]); end
    end
  endtask

  task automatic test_random();
    int w, nerr;
    bit done;
    bit v;
    logic [5:0] vl;
    logic [63:0] d;
    clear_all();
    nerr = 0;
    done = 1'b0;
    fork
      begin
        while (!done) begin
          @(posedge clk); #1;
          vec_ready = ($urandom_range(0, 3) != 0);
          sca_ready = $urandom_range(0, 1);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          v  = $urandom_range(0, 1);
          vl = 6'($urandom_range(0, 40));
          d  = {$urandom, $urandom};
          if (v) begin
            model_vec(vl, d, 1'b1);
            if (vl > 6'd32) nerr++;
          end else begin
            exp_s.push_back(d);
          end
          send(v, vl, d, w);
        end
        done = 1'b1;
      end
    join
    vec_ready = 1'b1; sca_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    comps += 3;
    if (vobs.size() != exp_v.size()) begin fails++; $display("FAIL rand_vec_count: got %0d want %0d", vobs.size(), exp_v.size()); end
    if (sobs.size() != exp_s.size()) begin fails++; $display("FAIL rand_sca_count: got %0d want %0d", sobs.size(), exp_s.size()); end
    if (vlerr_cnt != nerr) begin fails++; $display("FAIL rand_vl_err: got %0d want %0d", vlerr_cnt, nerr); end
    for (int j = 0; j < exp_v.size() && j < vobs.size(); j++) begin
      comps++;
      if (vobs[j] !== exp_v[j]) begin fails++; $display("FAIL rand_beat%0d: got %h want %h", j, vobs[j], exp_v[j]); end
    end
    for (int j = 0; j < exp_s.size() && j < sobs.size(); j++) begin
      comps++;
      if (sobs[j] !== exp_s[j]) begin fails++; $display("FAIL rand_sca%0d: got %h want %h", j, sobs[j], exp_s[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_vl10();
    test_vl_edges();
    test_stall();
    test_passthrough();
    test_reset_mid_split();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
